mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. Accepts one `md_operation` (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) with two operands from the execute stage and returns a 32-bit result after a fixed, operation-dependent latency. It uses a start/busy/done handshake, and the pipeline stalls while `busy` is high. `kill` aborts an in-flight operation on a pipeline flush.

---
 rtl/md_pkg.sv | 24 ++
 rtl/mul_div_unit_if.sv | 22 ++
 rtl/md_iter_core.sv | 67 ++++++
 rtl/mul_div_unit.sv | 164 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared RV32M multiply/divide definitions: op encodings, FSM states, default width.
// Op encodings are also consumed by the control decoder.
package md_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'b00,
        MD_CALC   = 2'b01,
        MD_FINISH = 2'b10
    } md_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage <-> multiply/divide unit handshake: start/busy/done with operands and result.
// master = execute stage, slave = mul_div_unit.
interface mul_div_unit_if #(parameter int XLEN = md_pkg::MD_XLEN);
    logic            start;
    logic [2:0]      md_operation;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, md_operation, operand_a, operand_b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, md_operation, operand_a, operand_b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/md_iter_core.sv
// Per-iteration datapath: shift-add multiply and restoring shift-subtract divide on magnitudes.
// hi/lo hold product {hi,lo} for multiply, remainder (hi) and quotient (lo) for divide.
module md_iter_core
    import md_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_mag_i,
    input  logic [XLEN-1:0] b_mag_i,
`ifdef MD_FAST_MUL_EN
    output logic [XLEN-1:0] mcand_o,
`endif
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic            is_div_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic            rem_ge;

    always_comb begin
        sum    = {1'b0, hi_q} + {1'b0, mcand_q & {XLEN{lo_q[0]}}};
        rem_sh = {hi_q, lo_q[XLEN-1]};
        rem_ge = rem_sh >= {1'b0, mcand_q};
        if (is_div_q) begin
            // Remainder always fits XLEN bits after a successful subtract.
            hi_d = rem_ge ? (rem_sh[XLEN-1:0] - mcand_q) : rem_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], rem_ge};
        end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_div_q <= 1'b0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (load_i) begin
            is_div_q <= is_div_i;
            mcand_q  <= is_div_i ? b_mag_i : a_mag_i;
            hi_q     <= '0;
            lo_q     <= is_div_i ? a_mag_i : b_mag_i;
        end else if (step_i) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef MD_FAST_MUL_EN
    assign mcand_o = mcand_q;
`endif
    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mul_div_unit.sv
// RV32M mul/div unit: FSM, operand conditioning, special cases, sign fix-up, result register.
// Latency 33 cycles iterative, 1 cycle for div-by-zero/overflow; MD_FAST_MUL_EN makes multiply 1 cycle.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic         clk,
    input  logic         reset,
    mul_div_unit_if.slave md
);

    localparam int DW = 2 * XLEN;
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q;
    md_op_e          op_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q;
    logic            neg_q, neg_a_q, special_q;
    logic [XLEN-1:0] special_res_q, result_q;

    md_op_e          op_in;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            is_div_in, div_zero, div_ovf, skip_calc;
    logic [XLEN-1:0] special_res;
    logic            accept, step;
    logic [XLEN-1:0] core_hi, core_lo;
    logic [DW-1:0]   prod_mag, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, normal_res;

    assign op_in     = md_op_e'(md.md_operation);
    assign is_div_in = md.md_operation[2];

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op_in)
            MD_MULH, MD_DIV, MD_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            MD_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_signed & md.operand_a[XLEN-1];
    assign b_neg = b_signed & md.operand_b[XLEN-1];
    assign a_mag = a_neg ? -md.operand_a : md.operand_a;
    assign b_mag = b_neg ? -md.operand_b : md.operand_b;

    assign div_zero = is_div_in && (md.operand_b == '0);
    assign div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                      (md.operand_a == INT_MIN) && (md.operand_b == '1);

    // md_operation[1] separates remainder ops from quotient ops.
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = md.md_operation[1] ? md.operand_a : '1;
        else if (div_ovf)
            special_res = md.md_operation[1] ? '0 : INT_MIN;
    end

`ifdef MD_FAST_MUL_EN
    logic [XLEN-1:0] core_mcand;
    assign skip_calc = div_zero | div_ovf | ~is_div_in;
    assign prod_mag  = DW'(core_mcand) * DW'(core_lo);
`else
    assign skip_calc = div_zero | div_ovf;
    assign prod_mag  = {core_hi, core_lo};
`endif

    assign accept = (state_q == MD_IDLE) && md.start && !md.kill;
    assign step   = (state_q == MD_CALC) && !md.kill;

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (accept),
        .step_i   (step),
        .is_div_i (is_div_in),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
`ifdef MD_FAST_MUL_EN
        .mcand_o  (core_mcand),
`endif
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

    assign prod_fix = neg_q   ? -prod_mag : prod_mag;
    assign quo_fix  = neg_q   ? -core_lo  : core_lo;
    assign rem_fix  = neg_a_q ? -core_hi  : core_hi;

    always_comb begin
        case (op_q)
            MD_MUL:                       normal_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: normal_res = prod_fix[DW-1:XLEN];
            MD_DIV, MD_DIVU:              normal_res = quo_fix;
            default:                      normal_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MD_IDLE;
            op_q          <= MD_MUL;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            neg_q         <= 1'b0;
            neg_a_q       <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            result_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (md.kill) begin
                state_q <= MD_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    MD_IDLE: begin
                        if (md.start) begin
                            op_q          <= op_in;
                            neg_q         <= a_neg ^ b_neg;
                            neg_a_q       <= a_neg;
                            special_q     <= div_zero | div_ovf;
                            special_res_q <= special_res;
                            busy_q        <= 1'b1;
                            cnt_q         <= '0;
                            state_q       <= skip_calc ? MD_FINISH : MD_CALC;
                        end
                    end
                    MD_CALC: begin
                        if (cnt_q == CW'(XLEN - 1)) begin
                            cnt_q   <= '0;
                            state_q <= MD_FINISH;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    MD_FINISH: begin
                        result_q <= special_q ? special_res_q : normal_res;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= MD_IDLE;
                    end
                    default: state_q <= MD_IDLE;
                endcase
            end
        end
    end

    assign md.busy   = busy_q;
    assign md.done   = done_q;
    assign md.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: results, latencies, special cases, start/kill/reset handling.
module tb_mul_div_unit;
    import md_pkg::*;

`ifdef MD_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.XLEN(32)) ifc ();

    mul_div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (ifc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge where done is seen.
    // inj >= 0 re-asserts start (a different op) during that cycle of the operation.
    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input int inj);
        int   lat;
        logic busy_ok;
        ifc.start        = 1'b1;
        ifc.md_operation = op;
        ifc.operand_a    = a;
        ifc.operand_b    = b;
        @(negedge clk);
        ifc.start        = 1'b0;
        ifc.operand_a    = $urandom;
        ifc.operand_b    = $urandom;
        ifc.md_operation = 3'($urandom_range(0, 7));
        lat     = 0;
        busy_ok = ifc.busy;
        while (!ifc.done && lat < 100) begin
            if (lat == inj) begin
                ifc.start        = 1'b1;
                ifc.md_operation = MD_MUL;
                ifc.operand_a    = 32'd3;
                ifc.operand_b    = 32'd5;
            end
            @(negedge clk);
            lat++;
            ifc.start = 1'b0;
            if (!ifc.done && !ifc.busy) busy_ok = 1'b0;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, ifc.result, exp);
        check({tag, "_busy_hold"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, ifc.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic seen;
        reset            = 1'b1;
        ifc.start        = 1'b0;
        ifc.kill         = 1'b0;
        ifc.md_operation = 3'd0;
        ifc.operand_a    = '0;
        ifc.operand_b    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, ifc.busy}, 32'd0);
        check("rst_done",   {31'd0, ifc.done}, 32'd0);
        check("rst_result", ifc.result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, -1);
        @(negedge clk);
        check("done_width", {31'd0, ifc.done}, 32'd0);

        // MULH followed back-to-back by MULHU issued in the done cycle
        run_op("mulh",   MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, -1);
        run_op("mulhu",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, -1);
        run_op("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, -1);
        run_op("mulh_neg", MD_MULH, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, MUL_LAT, -1);

        run_op("div",  MD_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, 5);
        run_op("rem",  MD_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, -1);
        run_op("divu", MD_DIVU, 32'd100,       32'd7, 32'd14,        DIV_LAT, -1);
        run_op("remu", MD_REMU, 32'd100,       32'd7, 32'd2,         DIV_LAT, -1);
        run_op("div_nb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, -1);
        run_op("rem_nb", MD_REM, 32'd7, 32'hFFFF_FFFE, 32'd1,         DIV_LAT, -1);

        run_op("div0",  MD_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1, -1);
        run_op("divu0", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, -1);
        run_op("rem0",  MD_REM,  32'd5, 32'd0, 32'd5,         1, -1);
        run_op("remu0", MD_REMU, 32'd5, 32'd0, 32'd5,         1, -1);

        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1);
        run_op("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, -1);

        // Kill at cycle 10 of a DIV; result must stay at the previous value (0)
        @(negedge clk);
        ifc.start        = 1'b1;
        ifc.md_operation = MD_DIV;
        ifc.operand_a    = 32'd1000;
        ifc.operand_b    = 32'd3;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (9) @(negedge clk);
        ifc.kill = 1'b1;
        @(negedge clk);
        ifc.kill = 1'b0;
        check("kill_busy",   {31'd0, ifc.busy}, 32'd0);
        check("kill_done",   {31'd0, ifc.done}, 32'd0);
        check("kill_result", ifc.result, 32'd0);
        run_op("after_kill", MD_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, -1);

        // start together with kill is not accepted
        @(negedge clk);
        ifc.start        = 1'b1;
        ifc.kill         = 1'b1;
        ifc.md_operation = MD_REMU;
        ifc.operand_a    = 32'd100;
        ifc.operand_b    = 32'd0;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.kill  = 1'b0;
        check("sk_busy", {31'd0, ifc.busy}, 32'd0);
        seen = ifc.done;
        repeat (3) begin
            @(negedge clk);
            seen = seen | ifc.done;
        end
        check("sk_no_done", {31'd0, seen}, 32'd0);
        check("sk_result",  ifc.result, 32'd14);

        // Reset mid-CALC clears everything
        ifc.start        = 1'b1;
        ifc.md_operation = MD_DIVU;
        ifc.operand_a    = 32'd1000;
        ifc.operand_b    = 32'd7;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", {31'd0, ifc.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy",   {31'd0, ifc.busy}, 32'd0);
        check("mid_rst_done",   {31'd0, ifc.done}, 32'd0);
        check("mid_rst_result", ifc.result, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
